// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns field-level requests into 32-bit words,
// tags each with a running PC and buffers them in a small output FIFO.
module instr_encoder #(
  parameter logic [31:0] PC_BASE = 32'h0000_3000,
  parameter int          DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_type,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        err,
  output logic [15:0] count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

  function automatic logic [31:0] encode(
    input logic [3:0]  t,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [15:0] imm,
    input logic [25:0] tgt
  );
    logic [31:0] w;
    case (t)
      4'd0:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100001};
      4'd1:    w = {6'b000000, rs, rt, rd, 5'b00000, 6'b100011};
      4'd2:    w = {6'b001101, rs, rt, imm};
      4'd3:    w = {6'b100011, rs, rt, imm};
      4'd4:    w = {6'b101011, rs, rt, imm};
      4'd5:    w = {6'b000100, rs, rt, imm};
      4'd6:    w = {6'b001111, 5'b00000, rt, imm};
      4'd7:    w = {6'b000010, tgt};
      4'd8:    w = {6'b000011, tgt};
      4'd9:    w = {6'b000000, rs, 15'b0, 6'b001000};
      4'd10:   w = {6'b000000, 5'b00000, rt, rd, sh, 6'b000000};
      4'd11:   w = {6'b001001, rs, rt, imm};
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   occ_q, occ_d;
  logic [31:0]   pc_q, pc_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d;
  logic          ready_q, valid_q;
  logic [31:0]   enc_s;
  logic          type_ok_s, accept_s, push_s, pop_s;

  // Next-state: handshake decode, FIFO pointers/occupancy, PC and counters
  always_comb begin
    enc_s     = encode(in_type, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
    type_ok_s = (in_type <= 4'd11);
    accept_s  = in_valid & ready_q;
    push_s    = accept_s & type_ok_s;
    pop_s     = valid_q & out_ready;
    wr_d      = wr_q;
    rd_d      = rd_q;
    occ_d     = occ_q;
    pc_d      = pc_q;
    count_d   = count_q;
    err_d     = err_q;

    if (push_s) begin
      wr_d = wr_q + AW'(1);
      pc_d = pc_q + 32'd4;
      if (count_q != 16'hFFFF) begin
        count_d = count_q + 16'd1;
      end else begin
        count_d = count_q;
      end
    end else begin
      wr_d = wr_q;
    end

    if (accept_s && !type_ok_s) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end

    if (pop_s) begin
      rd_d = rd_q + AW'(1);
    end else begin
      rd_d = rd_q;
    end

    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + (AW+1)'(1);
      2'b01:   occ_d = occ_q - (AW+1)'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state; ready/valid are registered from next-cycle occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      pc_q    <= PC_BASE;
      count_q <= 16'd0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      err_q   <= err_d;
      ready_q <= (occ_d != OCC_FULL);
      valid_q <= (occ_d != '0);
    end
  end

  // FIFO storage; cleared on reset so the outputs read zero while held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 64'd0;
      end
    end else if (push_s) begin
      mem_q[wr_q] <= {pc_q, enc_s};
    end else begin
      mem_q[wr_q] <= mem_q[wr_q];
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = valid_q;
  assign out_pc    = mem_q[rd_q][63:32];
  assign out_instr = mem_q[rd_q][31:0];
  assign err       = err_q;
  assign count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH = 2;
  localparam logic [31:0] PC_BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [3:0]  in_type;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm, count;
  logic [25:0] in_target;
  logic [31:0] out_pc, out_instr;

  instr_encoder #(.PC_BASE(PC_BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  int          m_count;
  logic        m_err;
  logic        m_ready;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_encode(input int t, input int rs, input int rt,
      input int rd, input int sh, input int imm, input int tgt);
    longint unsigned s26 = 64'd67108864, s21 = 64'd2097152, s16 = 64'd65536;
    longint unsigned s11 = 64'd2048, s6 = 64'd64, r;
    case (t)
      0:  r = rs * s21 + rt * s16 + rd * s11 + 33;
      1:  r = rs * s21 + rt * s16 + rd * s11 + 35;
      2:  r = 13 * s26 + rs * s21 + rt * s16 + imm;
      3:  r = 35 * s26 + rs * s21 + rt * s16 + imm;
      4:  r = 43 * s26 + rs * s21 + rt * s16 + imm;
      5:  r = 4 * s26 + rs * s21 + rt * s16 + imm;
      6:  r = 15 * s26 + rt * s16 + imm;
      7:  r = 2 * s26 + tgt;
      8:  r = 3 * s26 + tgt;
      9:  r = rs * s21 + 8;
      10: r = rt * s16 + rd * s11 + sh * s6;
      11: r = 9 * s26 + rs * s21 + rt * s16 + imm;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // compare outputs now (negedge), then advance one clock and update model
  task automatic cycle();
    logic acc, pop;
    check_eq("out_valid", out_valid, m_q.size() != 0);
    check_eq("in_ready", in_ready, m_ready);
    if (m_q.size() != 0) begin
      check_eq("out_pc", out_pc, m_q[0][63:32]);
      check_eq("out_instr", out_instr, m_q[0][31:0]);
    end
    check_eq("err", err, m_err);
    check_eq("count", count, m_count);
    acc = in_valid && m_ready;
    pop = (m_q.size() != 0) && out_ready;
    @(posedge clk);
    if (pop) void'(m_q.pop_front());
    if (acc) begin
      if (in_type < 12) begin
        m_q.push_back({m_pc, ref_encode(in_type, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target)});
        m_pc = m_pc + 32'd4;
        if (m_count < 65535) m_count++;
      end else begin
        m_err = 1'b1;
      end
    end
    m_ready = (m_q.size() != DEPTH);
    @(negedge clk);
  endtask

  task automatic set_req(input int t, input int rs, input int rt, input int rd,
      input int sh, input int imm, input int tgt);
    in_type = 4'(t); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
  endtask

  task automatic push(input int t, input int rs, input int rt, input int rd,
      input int sh, input int imm, input int tgt);
    set_req(t, rs, rt, rd, sh, imm, tgt);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    check_eq({tag, "_valid"}, out_valid, 1'b1);
    check_eq({tag, "_pc"}, out_pc, pc);
    check_eq({tag, "_instr"}, out_instr, ins);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    set_req(0, 0, 0, 0, 0, 0, 0);
    m_q.delete();
    m_pc = PC_BASE; m_count = 0; m_err = 1'b0; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_out_pc", out_pc, 32'd0);
    check_eq("rst_out_instr", out_instr, 32'd0);
    check_eq("rst_err", err, 1'b0);
    check_eq("rst_count", count, 16'd0);
    reset = 1'b1;
    cycle();
  endtask

  initial begin
    // addu after reset, one-cycle latency
    do_reset();
    out_ready = 1'b1;
    push(0, 1, 2, 3, 0, 0, 0);
    expect_head("addu", 32'h3000, 32'h0022_1821);
    cycle();

    // ori then lui (rs ignored)
    do_reset();
    push(2, 0, 1, 0, 0, 16'h1234, 0);
    push(6, 5, 1, 0, 0, 16'hFFFF, 0);
    expect_head("ori", 32'h3000, 32'h3401_1234);
    check_eq("count2", count, 16'd2);
    out_ready = 1'b1;
    cycle();
    expect_head("lui", 32'h3004, 32'h3C01_FFFF);
    cycle();

    // backpressure with a full FIFO
    do_reset();
    push(0, 4, 5, 6, 0, 0, 0);
    push(1, 7, 8, 9, 0, 0, 0);
    check_eq("full_in_ready", in_ready, 1'b0);
    set_req(11, 3, 4, 0, 0, 16'h8001, 0);
    in_valid = 1'b1;
    cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    expect_head("bp_second", 32'h3004, ref_encode(1, 7, 8, 9, 0, 0, 0));
    out_ready = 1'b1;
    repeat (3) cycle();

    // invalid type then jal
    do_reset();
    push(13, 1, 2, 3, 4, 5, 6);
    push(8, 0, 0, 0, 0, 0, 26'h0C00);
    check_eq("inv_err", err, 1'b1);
    expect_head("jal", 32'h3000, 32'h0C00_0C00);
    check_eq("count1", count, 16'd1);

    // jr then sll
    do_reset();
    push(9, 31, 7, 7, 7, 16'hFFFF, 0);
    push(10, 9, 2, 4, 3, 16'hFFFF, 0);
    expect_head("jr", 32'h3000, 32'h03E0_0008);
    out_ready = 1'b1;
    cycle();
    expect_head("sll", 32'h3004, 32'h0002_20C0);
    cycle();

    // asynchronous reset with two words buffered
    do_reset();
    push(0, 1, 1, 1, 0, 0, 0);
    push(0, 2, 2, 2, 0, 0, 0);
    #2 reset = 1'b0;
    #1 check_eq("async_out_valid", out_valid, 1'b0);
    do_reset();
    push(7, 0, 0, 0, 0, 0, 26'h3FF_FFFF);
    expect_head("post_rst", 32'h3000, 32'h0BFF_FFFF);
    check_eq("post_rst_err", err, 1'b0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 2) != 0);
      set_req($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
              $urandom_range(0, 67108863));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter PC_BASE, default 32'h0000_3000, is the PC assigned to the first encoded word after reset.
REQ-002 Parameter DEPTH, default 2, is the output FIFO entry count, power of two, minimum 2.
REQ-003 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 reset  input  1  is the asynchronous, active-low reset.
REQ-005 in_valid  input  1  means a request is offered.
REQ-006 in_ready  output  1  means a request is accepted this cycle when in_valid=1.
REQ-007 in_type  input  4  is the instruction type: 0 addu, 1 subu, 2 ori, 3 lw, 4 sw, 5 beq, 6 lui, 7 j, 8 jal, 9 jr, 10 sll, 11 addiu; 12-15 are invalid.
REQ-008 in_rs, in_rt, in_rd, in_shamt  input  5 each  are register and shift-amount fields.
REQ-009 in_imm  input  16  is the immediate/offset field.
REQ-010 in_target  input  26  is the jump target field.
REQ-011 out_valid  output  1  means out_pc/out_instr hold a word.
REQ-012 out_ready  input  1  means the consumer takes the word this cycle when out_valid=1.
REQ-013 out_pc  output  32  is the PC of the presented word.
REQ-014 out_instr  output  32  is the encoded MIPS word.
REQ-015 err  output  1  is a sticky flag: an invalid in_type was accepted.
REQ-016 count  output  16  is the number of valid words accepted since reset.

Function
REQ-017 Accept = in_valid & in_ready; in_ready = 1 iff FIFO not full (a same-cycle pop does not raise in_ready).
REQ-018 R-type addu/subu encode {6'b0, rs, rt, rd, 5'b0, funct} with funct 100001/100011.
REQ-019 sll encodes {6'b0, 5'b0, rt, rd, shamt, 6'b000000}; jr encodes {6'b0, rs, 15'b0, 6'b001000}.
REQ-020 I-type encodes {op, rs, rt, imm} with op ori 001101, lw 100011, sw 101011, beq 000100, addiu 001001.
REQ-021 lui encodes {001111, 5'b0, rt, imm}, ignoring in_rs.
REQ-022 j/jal encode {op, target} with op 000010/000011.
REQ-023 Fields not used by the selected format are ignored and contribute zeros.
REQ-024 A valid accept pushes {pc_cnt, encoding} into the FIFO, then pc_cnt += 4 (mod 2^32 wrap) and count += 1 (saturating at 16'hFFFF).
REQ-025 An invalid accept is consumed, pushes nothing, leaves pc_cnt and count unchanged, and sets err next cycle.
REQ-026 Latency: a word accepted in cycle N into an empty FIFO shows out_valid=1 in cycle N+1.
REQ-027 FIFO is first-in first-out; out_pc/out_instr stay stable while out_valid=1 and out_ready=0.
REQ-028 Simultaneous push and pop with the FIFO non-empty and not full keeps occupancy constant and preserves order.
REQ-029 Pop with the FIFO empty has no effect; push with the FIFO full is impossible (in_ready=0).
REQ-030 FIFO pointers wrap modulo DEPTH; full and empty are distinguished by an extra pointer bit or occupancy counter.

Reset
REQ-031 While reset=0: FIFO empty, out_valid=0, in_ready=0, err=0, count=0, pc_cnt=PC_BASE, out_pc=0, out_instr=0.
REQ-032 in_ready rises in the first clock edge after reset release.
REQ-033 Reset asserted mid-operation discards all buffered words immediately (asynchronous); no partial word is emitted afterward.

Verification
REQ-034 After reset, push addu rs=1 rt=2 rd=3 with out_ready=1 -> next cycle out_valid=1, out_pc=0x3000, out_instr=0x00221821.
REQ-035 Push ori rs=0 rt=1 imm=0x1234, then lui rt=1 imm=0xFFFF -> out_instr 0x34011234 at 0x3000, 0x3C01FFFF at 0x3004; count=2.
REQ-036 Hold out_ready=0 and push three words with DEPTH=2 -> in_ready=0 after two accepts; the third is accepted only after one pop; order is preserved.
REQ-037 Push in_type=13, then jal target=0x0C00 -> err=1, jal emitted at 0x3000 with out_instr 0x0C000C00; count=1.
REQ-038 Push jr rs=31, then sll rt=2 rd=4 shamt=3 -> 0x03E00008 at 0x3000, 0x000220C0 at 0x3004.
REQ-039 Assert reset while two words are buffered -> out_valid=0 at once; after release the next word appears at 0x3000 with err=0.
